// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM state
// encoding, requester count, index width and the rotating-priority pick.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // First set request bit scanning ptr, ptr+1, ... with 3-bit wraparound.
    // The loop runs from the farthest offset down so the nearest hit wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] idx;
        rr_pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               rel;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_vld;
    logic               timeout;

    modport master (
        output req,
        output rel,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld,
        input  timeout
    );

    modport slave (
        input  req,
        input  rel,
        output gnt,
        output gnt_idx,
        output gnt_vld,
        output timeout
    );

endinterface

// File: rtl/grant_decoder_3x8.sv
// 3-bit index to 8-bit one-hot decoder with enable; all zeros when disabled.
module grant_decoder_3x8
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    // One bit at most, and only while enabled.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with release strobe.
// Optional hold timeout enabled by defining ARB_TIMEOUT_EN; without it the
// owner keeps the grant until it releases or drops its request.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_IDLE  | no grant held; pick next requester from ptr if any request
//  ST_GRANT | gnt_idx owns the grant until rel, request drop or timeout
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter_8_if.slave  bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter_8: MAX_HOLD must be in 2..255");
    end

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic [IDX_W-1:0]   pick;
    logic [NUM_REQ-1:0] gnt_w;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    logic [7:0] hold_cnt;
    logic       timeout_q;
`endif

    // Rotating-priority candidate, only consumed in ST_IDLE.
    always_comb begin
        pick = rr_pick(bus.req, ptr);
    end

    // Arbitration FSM; owner index, pointer and timeout are all registered.
    // A normal release is checked before the hold limit so it wins a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gnt_idx_q <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef ARB_TIMEOUT_EN
                    timeout_q <= 1'b0;
`endif
                    if (bus.req != '0) begin
                        gnt_idx_q <= pick;
                        ptr       <= pick + IDX_W'(1);
                        state     <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt  <= 8'd1;
`endif
                    end
                end
                ST_GRANT: begin
                    if (bus.rel || !bus.req[gnt_idx_q]) begin
                        state <= ST_IDLE;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LIMIT) begin
                        state     <= ST_IDLE;
                        hold_cnt  <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    grant_decoder_3x8 u_dec (
        .idx    (gnt_idx_q),
        .en     (state == ST_GRANT),
        .onehot (gnt_w)
    );

    assign bus.gnt     = gnt_w;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_vld = (state == ST_GRANT);
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8 (MAX_HOLD = 4). Expected outputs are
// queued when a cycle's inputs are driven and compared after its edge.
module tb_rr_arbiter_8;

    logic clk;
    logic rst_n;
    int   err_cnt;
    int   chk_cnt;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       to;
    } exp_t;

    exp_t exp_q[$];

    rr_arbiter_8_if bus ();

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input exp_t e);
        check_val({tag, ".gnt"},     32'(bus.gnt),     32'(e.gnt));
        check_val({tag, ".gnt_idx"}, 32'(bus.gnt_idx), 32'(e.idx));
        check_val({tag, ".gnt_vld"}, 32'(bus.gnt_vld), 32'(e.vld));
        check_val({tag, ".timeout"}, 32'(bus.timeout), 32'(e.to));
    endtask

    // Drive one cycle of inputs, queue what must appear after the edge.
    task automatic step(input string tag, input logic [7:0] r, input logic rl,
                        input logic [7:0] eg, input logic [2:0] ei,
                        input logic ev, input logic et);
        exp_t e;
        bus.req = r;
        bus.rel = rl;
        exp_q.push_back('{gnt: eg, idx: ei, vld: ev, to: et});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_outs(tag, e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_outs("reset", '{gnt: 8'h00, idx: 3'd0, vld: 1'b0, to: 1'b0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        rst_n   = 1'b0;
        bus.req = 8'h00;
        bus.rel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single requester 0: one-cycle latency, then drop request.
        step("first",     8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        step("first_rel", 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        // rel in IDLE with no requests does nothing.
        step("idle_rel0", 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        step("idle_rel1", 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

        // All requesting, rel each grant: 01,00,02,00,...,80,00,01.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            logic [2:0] ix;
            logic [7:0] oh;
            ix = 3'(i % 8);
            oh = 8'h01 << ix;
            step($sformatf("rot%0d_g", i), 8'hFF, 1'b0, oh,    ix, 1'b1, 1'b0);
            step($sformatf("rot%0d_i", i), 8'hFF, 1'b1, 8'h00, ix, 1'b0, 1'b0);
        end

        // Owner 3 holds, 7 joins, owner drops: one IDLE cycle then 7.
        step("own3",      8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        step("own3_hold", 8'h88, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        step("own3_drop", 8'h80, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0);
        step("own7",      8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
        step("own7_drop", 8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Hold limit 4: four grant cycles, timeout on exit, regrant to 1.
        for (int i = 0; i < 4; i++) begin
            step($sformatf("hold%0d", i), 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        end
        step("to_exit",  8'h02, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1);
        step("regrant",  8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        step("rg_hold1", 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        step("rg_hold2", 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        step("rg_hold3", 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        // rel coinciding with the limit is a normal release.
        step("tie_rel",  8'h02, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0);
        step("tie_idle", 8'h00, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0);
`else
        // No timeout: requester 1 keeps the grant indefinitely.
        step("hold_start", 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("hold%0d", i), 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        end
        step("hold_drop", 8'h00, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0);
`endif

        // Reset during grant of 5 clears immediately; restart from index 0.
        step("own5", 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
        do_reset();
        step("post_rst",      8'h21, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        step("post_rst_idle", 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
